// File: rtl/ras_pkg.sv
// Shared definitions for the return-address stack: link offset, pointer-width helper
// and the checkpoint record the branch unit stores per in-flight branch.
package ras_pkg;

   localparam int unsigned RAS_LINK_OFFSET = 8;

   function automatic int unsigned ras_ptr_w(input int unsigned depth);
      return $clog2(depth);
   endfunction

   localparam int unsigned RAS_DEPTH = 16;
   localparam int unsigned RAS_PTR_W = ras_ptr_w(RAS_DEPTH);

   typedef struct packed {
      logic [RAS_PTR_W-1:0] ptr;
      logic [RAS_PTR_W:0]   count;
   } ras_ckpt_t;

endpackage

// File: rtl/ras_predictor_if.sv
// Fetch/decode-side bundle of the return-address stack: push, pop, recover and the
// registered prediction plus checkpoint outputs.
interface ras_predictor_if #(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned PTR_W  = $clog2(DEPTH)
);
   logic              push_valid;
   logic [ADDR_W-1:0] push_pc;
   logic              pop_valid;
   logic              recover_valid;
   logic [PTR_W-1:0]  recover_ptr;
   logic [PTR_W:0]    recover_count;
   logic              pred_valid;
   logic [ADDR_W-1:0] pred_pc;
   logic [PTR_W-1:0]  ckpt_ptr;
   logic [PTR_W:0]    ckpt_count;
   logic              empty;
   logic              full;

   modport master (
      output push_valid, push_pc, pop_valid, recover_valid, recover_ptr, recover_count,
      input  pred_valid, pred_pc, ckpt_ptr, ckpt_count, empty, full
   );

   modport slave (
      input  push_valid, push_pc, pop_valid, recover_valid, recover_ptr, recover_count,
      output pred_valid, pred_pc, ckpt_ptr, ckpt_count, empty, full
   );
endinterface

// File: rtl/ras_storage.sv
// DEPTH x ADDR_W register file: one synchronous write port, one combinational read port,
// all entries cleared by the asynchronous reset.
module ras_storage #(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned PTR_W  = $clog2(DEPTH)
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              we,
   input  logic [PTR_W-1:0]  waddr,
   input  logic [ADDR_W-1:0] wdata,
   input  logic [PTR_W-1:0]  raddr,
   output logic [ADDR_W-1:0] rdata
);
   logic [ADDR_W-1:0] mem_q [DEPTH];

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];
endmodule

// File: rtl/ras_predictor.sv
// Return-address stack with circular overwrite on overflow and pointer checkpoint/restore;
// holds the ptr/count control, recover/push/pop priority and the prediction registers.
module ras_predictor
   import ras_pkg::*;
#(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned PTR_W  = ras_ptr_w(DEPTH)
) (
   input logic             CLK,
   input logic             RESET,
   ras_predictor_if.slave  ras
);
   localparam logic [PTR_W:0] DepthC = (PTR_W+1)'(DEPTH);

   logic [PTR_W-1:0]  ptr_q, ptr_d, top_ptr, waddr;
   logic [PTR_W:0]    count_q, count_d;
   logic              pred_valid_q, pred_valid_d;
   logic [ADDR_W-1:0] pred_pc_q, pred_pc_d, link, top_data;
   logic              we, has_entry;

   assign top_ptr   = ptr_q - 1'b1;
   assign link      = ras.push_pc + ADDR_W'(RAS_LINK_OFFSET);
   assign has_entry = (count_q != '0);

   ras_storage #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .PTR_W  (PTR_W)
   ) u_storage (
      .CLK   (CLK),
      .RESET (RESET),
      .we    (we),
      .waddr (waddr),
      .wdata (link),
      .raddr (top_ptr),
      .rdata (top_data)
   );

   always_comb begin
      ptr_d        = ptr_q;
      count_d      = count_q;
      pred_valid_d = 1'b0;
      pred_pc_d    = pred_pc_q;
      we           = 1'b0;
      waddr        = ptr_q;
      if (ras.recover_valid) begin
         ptr_d   = ras.recover_ptr;
         count_d = (ras.recover_count > DepthC) ? DepthC : ras.recover_count;
      end else begin
         if (ras.pop_valid && has_entry) begin
            pred_valid_d = 1'b1;
            pred_pc_d    = top_data;
         end
         // Push+pop with a live top replaces the top in place: net depth unchanged.
         if (ras.push_valid && ras.pop_valid && has_entry) begin
            we    = 1'b1;
            waddr = top_ptr;
         end else if (ras.push_valid) begin
            we      = 1'b1;
            ptr_d   = ptr_q + 1'b1;
            count_d = (count_q == DepthC) ? count_q : count_q + 1'b1;
         end else if (ras.pop_valid && has_entry) begin
            ptr_d   = top_ptr;
            count_d = count_q - 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         ptr_q        <= '0;
         count_q      <= '0;
         pred_valid_q <= 1'b0;
         pred_pc_q    <= '0;
      end else begin
         ptr_q        <= ptr_d;
         count_q      <= count_d;
         pred_valid_q <= pred_valid_d;
         pred_pc_q    <= pred_pc_d;
      end
   end

   assign ras.pred_valid = pred_valid_q;
   assign ras.pred_pc    = pred_pc_q;
   assign ras.ckpt_ptr   = ptr_q;
   assign ras.ckpt_count = count_q;
   assign ras.empty      = (count_q == '0);
   assign ras.full       = (count_q == DepthC);
endmodule

// File: tb/tb_ras_predictor.sv
// Self-checking bench for ras_predictor (DEPTH=4): directed scenarios plus random traffic,
// all compared against a behavioural stack model.
module tb_ras_predictor;
   localparam int D = 4;
   localparam int AW = 32;
   localparam int PW = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ras_predictor_if #(.DEPTH(D), .ADDR_W(AW), .PTR_W(PW)) bus ();

   ras_predictor #(.DEPTH(D), .ADDR_W(AW)) dut (
      .CLK   (clk),
      .RESET (rst_n),
      .ras   (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   logic [AW-1:0] m_stack [D];
   int            m_ptr, m_cnt;
   logic          m_pv;
   logic [AW-1:0] m_ppc;
   logic [PW-1:0] cap_ptr;
   logic [PW:0]   cap_cnt;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < D; i++) m_stack[i] = '0;
      m_ptr = 0;
      m_cnt = 0;
      m_pv  = 1'b0;
      m_ppc = '0;
   endtask

   task automatic check_model(input string tag);
      check({tag, ".pred_valid"}, 64'(bus.pred_valid), 64'(m_pv));
      check({tag, ".pred_pc"},    64'(bus.pred_pc),    64'(m_ppc));
      check({tag, ".ckpt_ptr"},   64'(bus.ckpt_ptr),   64'(m_ptr));
      check({tag, ".ckpt_count"}, 64'(bus.ckpt_count), 64'(m_cnt));
      check({tag, ".empty"},      64'(bus.empty),      64'(m_cnt == 0));
      check({tag, ".full"},       64'(bus.full),       64'(m_cnt == D));
   endtask

   task automatic idle_inputs();
      bus.push_valid    = 1'b0;
      bus.push_pc       = '0;
      bus.pop_valid     = 1'b0;
      bus.recover_valid = 1'b0;
      bus.recover_ptr   = '0;
      bus.recover_count = '0;
   endtask

   // Apply one cycle of inputs, advance the model by the stack rules, compare after the edge.
   task automatic step(input string tag, input logic push, input logic [AW-1:0] pc,
                       input logic pop, input logic rec, input logic [PW-1:0] rptr,
                       input logic [PW:0] rcnt);
      logic [AW-1:0] link;
      int top;
      bus.push_valid    = push;
      bus.push_pc       = pc;
      bus.pop_valid     = pop;
      bus.recover_valid = rec;
      bus.recover_ptr   = rptr;
      bus.recover_count = rcnt;
      @(posedge clk);
      link = pc + 32'd8;
      top  = (m_ptr + D - 1) % D;
      if (rec) begin
         m_ptr = int'(rptr);
         m_cnt = (int'(rcnt) > D) ? D : int'(rcnt);
         m_pv  = 1'b0;
      end else begin
         m_pv = 1'b0;
         if (pop && m_cnt > 0) begin
            m_pv  = 1'b1;
            m_ppc = m_stack[top];
         end
         if (push && pop && m_cnt > 0) begin
            m_stack[top] = link;
         end else if (push) begin
            m_stack[m_ptr] = link;
            m_ptr = (m_ptr + 1) % D;
            if (m_cnt < D) m_cnt++;
         end else if (pop && m_cnt > 0) begin
            m_ptr = top;
            m_cnt--;
         end
      end
      #1;
      idle_inputs();
      check_model(tag);
   endtask

   task automatic push_op(input string tag, input logic [AW-1:0] pc);
      step(tag, 1'b1, pc, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic pop_op(input string tag);
      step(tag, 1'b0, '0, 1'b1, 1'b0, '0, '0);
   endtask

   task automatic do_reset();
      #1;
      rst_n = 1'b0;
      #2;
      model_reset();
      check_model("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle_inputs();
      model_reset();
      #3;
      check_model("por");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      pop_op("pop_empty");
      check("pop_empty.pv", 64'(bus.pred_valid), 64'd0);
      check("pop_empty.empty", 64'(bus.empty), 64'd1);

      push_op("t2_push1", 32'h0040_0100);
      push_op("t2_push2", 32'h0040_0200);
      pop_op("t2_pop1");
      check("t2_pop1.pc", 64'(bus.pred_pc), 64'h0040_0208);
      pop_op("t2_pop2");
      check("t2_pop2.pc", 64'(bus.pred_pc), 64'h0040_0108);
      pop_op("t2_pop3");
      check("t2_pop3.pv", 64'(bus.pred_valid), 64'd0);

      do_reset();
      for (int i = 1; i <= 5; i++) begin
         push_op("t3_push", AW'(i * 16));
         if (i == 4) check("t3_full4", 64'(bus.full), 64'd1);
      end
      check("t3_count5", 64'(bus.ckpt_count), 64'd4);
      for (int i = 0; i < 4; i++) begin
         pop_op("t3_pop");
         check("t3_pop.pc", 64'(bus.pred_pc), 64'(32'h58 - 32'(i * 16)));
      end
      pop_op("t3_pop5");
      check("t3_pop5.pv", 64'(bus.pred_valid), 64'd0);

      do_reset();
      push_op("t4_push", 32'h100);
      step("t4_pushpop", 1'b1, 32'h200, 1'b1, 1'b0, '0, '0);
      check("t4_pushpop.pc", 64'(bus.pred_pc), 64'h108);
      pop_op("t4_pop");
      check("t4_pop.pc", 64'(bus.pred_pc), 64'h208);
      check("t4_pop.count", 64'(bus.ckpt_count), 64'd0);

      do_reset();
      push_op("t5_push", 32'h100);
      cap_ptr = bus.ckpt_ptr;
      cap_cnt = bus.ckpt_count;
      push_op("t5_push3", 32'h300);
      push_op("t5_push4", 32'h400);
      step("t5_recover", 1'b1, 32'h500, 1'b1, 1'b1, cap_ptr, cap_cnt);
      check("t5_recover.count", 64'(bus.ckpt_count), 64'd1);
      pop_op("t5_pop");
      check("t5_pop.pc", 64'(bus.pred_pc), 64'h108);
      check("t5_pop.count", 64'(bus.ckpt_count), 64'd0);

      push_op("t6_push", 32'hFFFF_FFFC);
      pop_op("t6_pop");
      check("t6_pop.pc", 64'(bus.pred_pc), 64'h4);
      push_op("t6_push2", 32'h1234);
      pop_op("t6_pop2");
      do_reset();
      check("t6_reset.pc", 64'(bus.pred_pc), 64'd0);

      for (int i = 0; i < 400; i++) begin
         step("rand",
              1'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 15) == 0), PW'($urandom), (PW+1)'($urandom));
         if (i == 200) do_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/ras_predictor.md
# ras_predictor

Parametrised return-address stack for the fetch-stage branch predictor. It pushes a link address when decode confirms a jump-and-link and supplies a registered return-target prediction when fetch sees a return. It adds three things over the single-depth design: configurable depth and address width, circular overwrite on overflow, and pointer checkpoint/restore for misprediction recovery. It sits beside the BTB/direction predictor; fetch muxes `pred_pc` into next-PC when `pred_valid` is high.

## Interface
- `DEPTH`, 16: number of entries; must be a power of two, ≥2.
- `ADDR_W`, 32: address width.
- `PTR_W`, $clog2(DEPTH): pointer width (derived; do not override).
- `CLK`, input, 1: clock; all state updates on the rising edge.
- `RESET`, input, 1: asynchronous, active-low reset.
- `push_valid`, input, 1: decode-stage jump-and-link this cycle.
- `push_pc`, input, ADDR_W: PC of that jump-and-link.
- `pop_valid`, input, 1: fetch-stage return (JR $ra) detected this cycle.
- `recover_valid`, input, 1: restore the pointer state from a checkpoint.
- `recover_ptr`, input, PTR_W: checkpointed pointer.
- `recover_count`, input, PTR_W+1: checkpointed occupancy.
- `pred_valid`, output, 1: `pred_pc` is a valid return prediction.
- `pred_pc`, output, ADDR_W: predicted return target.
- `ckpt_ptr`, output, PTR_W: current pointer, for the branch unit to snapshot.
- `ckpt_count`, output, PTR_W+1: current occupancy, for snapshot.
- `empty`, output, 1: count == 0.
- `full`, output, 1: count == DEPTH.

## Operation
- State: `stack[DEPTH]` of ADDR_W; `ptr` (next free slot, top is `ptr-1`); `count` in 0..DEPTH.
- Pointer arithmetic is modulo DEPTH (natural PTR_W wrap).
- Link value is `push_pc + 8`, truncated to ADDR_W (carry-out dropped).
- Push only:
  - Write `stack[ptr]` with the link value; `ptr+1`.
  - `count` increments, saturating at DEPTH. On a full push the oldest entry is overwritten silently.
- Pop only, with count > 0:
  - `pred_pc <= stack[ptr-1]`, `pred_valid <= 1`, `ptr-1`, `count-1`.
- Pop only, with count == 0:
  - `pred_valid <= 0`; `pred_pc` holds its value; no state change (underflow never wraps).
- Push and pop together, with count > 0:
  - Prediction is taken from the old `stack[ptr-1]`.
  - The link value is then written into `stack[ptr-1]`; `ptr` and `count` are unchanged.
- Push and pop together, with count == 0: behaves as push only; `pred_valid <= 0`.
- `recover_valid` has priority over push and pop in the same cycle:
  - `ptr <= recover_ptr`, `count <= min(recover_count, DEPTH)`.
  - `pred_valid <= 0`; stack contents are untouched.
  - Stale entries may later mispredict; this is accepted.
- Neither pop nor recover: `pred_valid <= 0`; `pred_pc` holds.
- `ckpt_ptr`, `ckpt_count`, `empty` and `full` are combinational from the registered state (pre-update values in the cycle of use).

## Timing
- Reset (asynchronous, RESET low): all stack entries 0, `ptr` 0, `count` 0, `pred_valid` 0, `pred_pc` 0. Outputs are therefore `empty` 1, `full` 0, `ckpt_*` 0.
- Reset asserted mid-operation clears everything immediately; the first edge after release behaves as from reset.
- Pop at cycle N gives `pred_valid`/`pred_pc` at cycle N+1, registered, valid for exactly one cycle.
- Push at cycle N is visible to a pop at cycle N+1 (one-cycle write-to-read).
- A push and pop in the same cycle follow the combined rule above, with no internal bypass.
- Recover at cycle N: pointer state takes effect at N+1; a pop at N+1 reads from the restored top.
- No stalls and no back-pressure: every input is consumed in the cycle it is presented.

## Structure
- Shared package `ras_pkg`:
  - `RAS_LINK_OFFSET = 8`.
  - Typedef `ras_ckpt_t` {ptr, count}, used by the branch unit to store checkpoints.
  - Function `ras_ptr_w(depth)`.
- Sub-module `ras_storage`:
  - DEPTH×ADDR_W register file, one write port and one combinational read port, reset to 0.
- `ras_predictor` holds the ptr/count control, priority logic and output registers.

## Test plan
- Reset, then pop: `pred_valid` is 0 next cycle; `ptr` 0, `count` 0, `empty` 1.
- Push `push_pc` 0x0040_0100, push 0x0040_0200, then pop, pop:
  - `pred_pc` is 0x0040_0208 and then 0x0040_0108, each with `pred_valid` 1.
  - A third pop gives `pred_valid` 0.
- DEPTH=4: push 5 calls with PCs 0x10, 0x20, 0x30, 0x40, 0x50.
  - `full` 1 after the fourth push; `count` stays 4 after the fifth.
  - Four pops return 0x58, 0x48, 0x38, 0x28; the fifth pop gives `pred_valid` 0.
- Push 0x100, then push 0x200 and pop in the same cycle:
  - `pred_pc` is 0x108.
  - A following pop returns 0x208; `count` ends at 0.
- Capture `ckpt_*` after one push of 0x100, then push 0x300 and 0x400, then recover with the captured values, then pop:
  - The pop returns 0x108; `count` goes 1 → 0.
- Push `push_pc` 0xFFFF_FFFC then pop: `pred_pc` is 0x0000_0004. Assert RESET mid-sequence: all outputs return to their reset values asynchronously.
